data_mem_port: RTL and testbench
================================

// Module: data_mem_port
// PURPOSE
//  Downstream stage of the CPU data path: takes the CPU's load/store request and drives a word-wide, byte-enable-less
//  memory over a req/ack handshake. Byte/half stores become read-modify-write sequences; loads return the addressed
//  lane right-justified in rData, ready for the CPU's sign/zero extension. stall holds the CPU (gates its enable).
// PARAMETERS
//  DataWidth     32  CPU and memory word width (multiple of 8, >=32)
//  DataAddrWidth 32  CPU byte-address width
//  MemAddrWidth  16  memory word-address width; memAddr = dataAddr[MemAddrWidth+1:2]
// PORTS
//  clock     in   1              sole clock, all state on posedge
//  reset     in   1              asynchronous, active-high
//  read      in   1              CPU load request (level, held while stalled)
//  write     in   1              CPU store request (level, held while stalled)
//  lsLength  in   2              00 byte, 01 half, 11 word; 10 illegal
//  dataAddr  in   DataAddrWidth  byte address
//  wData     in   DataWidth      store data, lane right-justified
//  rData     out  DataWidth      load data, lane right-justified, upper bits zero
//  stall     out  1              hold CPU this cycle
//  misalign  out  1              one-cycle pulse: rejected access
//  memReq    out  1              memory request, held until memAck
//  memWrite  out  1              1 write, 0 read; stable while memReq
//  memAddr   out  MemAddrWidth   word address; stable while memReq
//  memWData  out  DataWidth      full merged word
//  memRData  in   DataWidth      valid when memAck=1 on a read
//  memAck    in   1              completes current access (any latency >=0 cycles after memReq)
// BEHAVIOUR
//  Reset: state IDLE; rData=0, stall=0, misalign=0, memReq=0, memWrite=0, memAddr=0, memWData=0; reset mid-access
//   drops memReq immediately (async) and discards the access; no completion is reported.
//  States: IDLE, READ, WRITE, DONE, ERR.
//  IDLE: read|write -> capture addr/lsLength/wData/op; stall=1 combinationally in this cycle.
//   Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or lsLength=10 -> ERR. read&write both high -> store
//   wins. Load or sub-word store -> READ; word store -> WRITE.
//  READ: memReq=1, memWrite=0. On memAck: load -> capture extracted lane into rData, -> DONE;
//   store -> merge wData lane into memRData into memWData, -> WRITE.
//  WRITE: memReq=1, memWrite=1, memWData=merged (word store: wData). On memAck -> DONE.
//  DONE: stall=0 for exactly one cycle (CPU advances on this edge); inputs ignored; -> IDLE.
//  ERR: stall=0, misalign=1, rData=0, no memory access; -> IDLE.
//  stall=1 in IDLE-with-request, READ, WRITE; 0 in DONE, ERR, idle IDLE.
//  memReq deasserts on the edge after memAck; back-to-back requests need >=1 IDLE cycle.
//  Lane select (little-endian): byte lane = addr[1:0], half lane = addr[1]; bytes outside the lane are preserved on
//   stores, zeroed on loads. rData holds its value until the next completed load or reset.
//  Latency with memAck on first memReq cycle: word load/store 3 cycles to DONE, sub-word store 4.
// STRUCTURE
//  Shared package: MemStateEnum {IDLE,READ,WRITE,DONE,ERR}; LsLength constants BYTE=2'b00, HALF=2'b01,
//   WORD=2'b11.
//  Sub-module lane_merger (combinational): extract(word, addr, len) and merge(old, new, addr, len); FSM, capture
//   registers and handshake stay in data_mem_port.
// TESTING
//  Word load addr 0x10, memRData=0xDEADBEEF, ack after 2 cycles -> memAddr=4, rData=0xDEADBEEF, stall high 4 cycles.
//  Byte store 0xAB at addr 0x13, old word 0x11223344 -> read then write memWData=0xAB223344.
//  Half load addr 0x22, memRData=0xCAFE1234 -> rData=0x0000CAFE.
//  Word load addr 0x06 -> misalign pulse, rData=0, memReq never asserted, stall only in request cycle.
//  Reset asserted while in WRITE before ack -> memReq, stall low immediately; next access starts clean from IDLE.
//  Zero-wait-state memory (memAck tied 1): half store 0xBEEF at addr 0x0 over 0xFFFFFFFF -> 0xFFFFBEEF, DONE 4th
//   cycle.

Source files
------------

// File: rtl/data_mem_port_pkg.sv
// Shared types for the CPU-side data memory port: FSM states, access lengths
// and the alignment rule used to reject accesses before they reach memory.
package data_mem_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        ERR
    } MemStateEnum;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b11;

    // 2'b10 is not a legal length and is rejected like a misaligned access
    function automatic logic access_bad(input logic [1:0] lane, input logic [1:0] len);
        case (len)
            BYTE:    access_bad = 1'b0;
            HALF:    access_bad = lane[0];
            WORD:    access_bad = (lane != 2'b00);
            default: access_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_port_lane_merger.sv
// Little-endian lane handling: pulls the addressed byte/half out of a memory word
// (right-justified, upper bits zero) and folds a store lane into an old word.
module lane_merger
    import data_mem_port_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] old_word,
    input  logic [DataWidth-1:0] new_data,
    input  logic [1:0]           addr,
    input  logic [1:0]           len,
    output logic [DataWidth-1:0] extracted,
    output logic [DataWidth-1:0] merged
);

    localparam logic [DataWidth-1:0] BYTE_MASK = DataWidth'(8'hFF);
    localparam logic [DataWidth-1:0] HALF_MASK = DataWidth'(16'hFFFF);

    logic [4:0]           shift;
    logic [DataWidth-1:0] lane_mask;

    always_comb begin
        shift     = 5'd0;
        lane_mask = '1;
        extracted = old_word;
        merged    = new_data;
        case (len)
            BYTE: begin
                shift     = {addr, 3'b000};
                lane_mask = BYTE_MASK << shift;
                extracted = (old_word >> shift) & BYTE_MASK;
                merged    = (old_word & ~lane_mask) | ((new_data & BYTE_MASK) << shift);
            end
            HALF: begin
                shift     = {addr[1], 4'b0000};
                lane_mask = HALF_MASK << shift;
                extracted = (old_word >> shift) & HALF_MASK;
                merged    = (old_word & ~lane_mask) | ((new_data & HALF_MASK) << shift);
            end
            default: begin
                extracted = old_word;
                merged    = new_data;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// CPU load/store front end for a word-wide memory without byte enables; sub-word
// stores become read-modify-write, and the CPU is stalled until the access completes.
module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int DataAddrWidth = 32,
    parameter int MemAddrWidth  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [1:0]               lsLength,
    input  logic [DataAddrWidth-1:0] dataAddr,
    input  logic [DataWidth-1:0]     wData,
    output logic [DataWidth-1:0]     rData,
    output logic                     stall,
    output logic                     misalign,
    output logic                     memReq,
    output logic                     memWrite,
    output logic [MemAddrWidth-1:0]  memAddr,
    output logic [DataWidth-1:0]     memWData,
    input  logic [DataWidth-1:0]     memRData,
    input  logic                     memAck
);

    MemStateEnum          state, next_state;
    logic                 request, bad;
    logic                 op_store;
    logic [1:0]           len_q, lane_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] extracted, merged;
    logic                 unused_addr;

    assign request     = read | write;
    assign bad         = access_bad(dataAddr[1:0], lsLength);
    assign unused_addr = ^dataAddr[DataAddrWidth-1:MemAddrWidth+2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request) begin
                    if (bad)                           next_state = ERR;
                    else if (write && lsLength == WORD) next_state = WRITE;
                    else                               next_state = READ;
                end
            end
            READ:    if (memAck) next_state = op_store ? WRITE : DONE;
            WRITE:   if (memAck) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        memReq   = (state == READ) || (state == WRITE);
        memWrite = (state == WRITE);
        misalign = (state == ERR);
        stall    = memReq || (state == IDLE && request);
    end

    // Request context is only read after capture, so it needs no reset
    always_ff @(posedge clock) begin
        if (state == IDLE && request) begin
            op_store <= write;
            len_q    <= lsLength;
            lane_q   <= dataAddr[1:0];
            wdata_q  <= wData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rData    <= '0;
            memAddr  <= '0;
            memWData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && bad) begin
                        rData <= '0;
                    end else if (request) begin
                        memAddr <= dataAddr[MemAddrWidth+1:2];
                        if (write) memWData <= wData;
                    end
                end
                READ: begin
                    if (memAck) begin
                        if (op_store) memWData <= merged;
                        else          rData    <= extracted;
                    end
                end
                default: ;
            endcase
        end
    end

    lane_merger #(
        .DataWidth(DataWidth)
    ) u_lane_merger (
        .old_word (memRData),
        .new_data (wdata_q),
        .addr     (lane_q),
        .len      (len_q),
        .extracted(extracted),
        .merged   (merged)
    );

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port with a small memory responder of programmable
// acknowledge latency that records every completed read and write.
module tb_data_mem_port;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [1:0]  lsLength = 2'b00;
    logic [31:0] dataAddr = '0, wData = '0;
    logic [31:0] rData, memWData, memRData;
    logic        stall, misalign, memReq, memWrite, memAck;
    logic [15:0] memAddr;

    int vectors = 0;
    int miscompares = 0;

    // memory responder
    logic [31:0] rd_word = '0;
    int          ack_delay = 0;
    int          req_cnt = 0;
    logic [31:0] wr_data = '0;
    logic [15:0] wr_addr = '0;
    int          wr_count = 0;
    int          rd_count = 0;

    assign memAck   = memReq && (req_cnt >= ack_delay);
    assign memRData = rd_word;

    always @(posedge clock) begin
        if (memReq && !memAck) req_cnt <= req_cnt + 1;
        else                   req_cnt <= 0;
        if (memReq && memAck && memWrite) begin
            wr_data  <= memWData;
            wr_addr  <= memAddr;
            wr_count <= wr_count + 1;
        end
        if (memReq && memAck && !memWrite) rd_count <= rd_count + 1;
    end

    always #5 clock = ~clock;

    data_mem_port #(
        .DataWidth(32), .DataAddrWidth(32), .MemAddrWidth(16)
    ) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .lsLength(lsLength), .dataAddr(dataAddr), .wData(wData),
        .rData(rData), .stall(stall), .misalign(misalign),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
        .memWData(memWData), .memRData(memRData), .memAck(memAck)
    );

    // Drives one CPU request and follows it to the first non-stalled cycle
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] len,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output int stalls, output int cycles, output logic saw_req,
                             output logic saw_mis, output logic [15:0] req_addr,
                             output logic timed_out);
        @(posedge clock);
        #1;
        read = rd; write = wr; lsLength = len; dataAddr = addr; wData = wd;
        stalls = 0; cycles = 0; saw_req = 1'b0; saw_mis = 1'b0;
        req_addr = '0; timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            cycles = i + 1;
            if (memReq && !saw_req) begin
                saw_req  = 1'b1;
                req_addr = memAddr;
            end
            if (misalign) saw_mis = 1'b1;
            if (stall) stalls++;
            else begin
                read = 1'b0; write = 1'b0;
                timed_out = 1'b0;
                break;
            end
        end
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors += 7;
        if (stall !== 1'b0)    begin miscompares++; $display("FAIL reset_stall got %b want 0", stall); end
        if (misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %b want 0", misalign); end
        if (memReq !== 1'b0)   begin miscompares++; $display("FAIL reset_memReq got %b want 0", memReq); end
        if (memWrite !== 1'b0) begin miscompares++; $display("FAIL reset_memWrite got %b want 0", memWrite); end
        if (memAddr !== 16'h0) begin miscompares++; $display("FAIL reset_memAddr got %h want 0", memAddr); end
        if (memWData !== 32'h0) begin miscompares++; $display("FAIL reset_memWData got %h want 0", memWData); end
        if (rData !== 32'h0)   begin miscompares++; $display("FAIL reset_rData got %h want 0", rData); end
        reset = 1'b0;
    endtask

    task automatic test_word_load;
        int st, cy; logic rq, ms, to; logic [15:0] ra;
        ack_delay = 2; rd_word = 32'hDEADBEEF;
        do_access(1'b1, 1'b0, 2'b11, 32'h10, 32'h0, st, cy, rq, ms, ra, to);
        vectors += 4;
        if (to !== 1'b0)          begin miscompares++; $display("FAIL wload_timeout got %b want 0", to); end
        if (ra !== 16'h4)         begin miscompares++; $display("FAIL wload_memAddr got %h want 0004", ra); end
        if (rData !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wload_rData got %h want deadbeef", rData); end
        if (st != 4)              begin miscompares++; $display("FAIL wload_stall_cycles got %0d want 4", st); end
    endtask

    task automatic test_byte_store;
        int st, cy, w0, r0; logic rq, ms, to; logic [15:0] ra;
        ack_delay = 1; rd_word = 32'h11223344;
        w0 = wr_count; r0 = rd_count;
        do_access(1'b0, 1'b1, 2'b00, 32'h13, 32'h000000AB, st, cy, rq, ms, ra, to);
        vectors += 6;
        if (to !== 1'b0)            begin miscompares++; $display("FAIL bstore_timeout got %b want 0", to); end
        if (wr_data !== 32'hAB223344) begin miscompares++; $display("FAIL bstore_wdata got %h want ab223344", wr_data); end
        if (wr_addr !== 16'h4)      begin miscompares++; $display("FAIL bstore_waddr got %h want 0004", wr_addr); end
        if (rd_count - r0 != 1)     begin miscompares++; $display("FAIL bstore_reads got %0d want 1", rd_count - r0); end
        if (wr_count - w0 != 1)     begin miscompares++; $display("FAIL bstore_writes got %0d want 1", wr_count - w0); end
        if (st != 5)                begin miscompares++; $display("FAIL bstore_stall_cycles got %0d want 5", st); end
    endtask

    task automatic test_subword_load;
        int st, cy; logic rq, ms, to; logic [15:0] ra;
        ack_delay = 0; rd_word = 32'hCAFE1234;
        do_access(1'b1, 1'b0, 2'b01, 32'h22, 32'h0, st, cy, rq, ms, ra, to);
        vectors += 3;
        if (rData !== 32'h0000CAFE) begin miscompares++; $display("FAIL hload_rData got %h want 0000cafe", rData); end
        if (ra !== 16'h8)           begin miscompares++; $display("FAIL hload_memAddr got %h want 0008", ra); end
        if (cy != 3)                begin miscompares++; $display("FAIL hload_latency got %0d want 3", cy); end
        rd_word = 32'h11223344;
        do_access(1'b1, 1'b0, 2'b00, 32'h13, 32'h0, st, cy, rq, ms, ra, to);
        vectors += 1;
        if (rData !== 32'h00000011) begin miscompares++; $display("FAIL bload_rData got %h want 00000011", rData); end
    endtask

    task automatic test_misalign;
        int st, cy; logic rq, ms, to; logic [15:0] ra;
        do_access(1'b1, 1'b0, 2'b11, 32'h06, 32'h0, st, cy, rq, ms, ra, to);
        vectors += 5;
        if (ms !== 1'b1)     begin miscompares++; $display("FAIL mis_pulse got %b want 1", ms); end
        if (rq !== 1'b0)     begin miscompares++; $display("FAIL mis_memReq got %b want 0", rq); end
        if (rData !== 32'h0) begin miscompares++; $display("FAIL mis_rData got %h want 0", rData); end
        if (st != 1)         begin miscompares++; $display("FAIL mis_stall_cycles got %0d want 1", st); end
        @(negedge clock);
        if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis_one_cycle got %b want 0", misalign); end
        do_access(1'b0, 1'b1, 2'b10, 32'h00, 32'h1, st, cy, rq, ms, ra, to);
        vectors += 2;
        if (ms !== 1'b1) begin miscompares++; $display("FAIL illegal_len_pulse got %b want 1", ms); end
        if (rq !== 1'b0) begin miscompares++; $display("FAIL illegal_len_memReq got %b want 0", rq); end
    endtask

    task automatic test_reset_mid_write;
        int st, cy, w0; logic rq, ms, to; logic [15:0] ra;
        ack_delay = 100; w0 = wr_count;
        @(posedge clock);
        #1;
        write = 1'b1; lsLength = 2'b11; dataAddr = 32'h40; wData = 32'h12345678;
        @(negedge clock);
        @(negedge clock);
        vectors += 2;
        if (memReq !== 1'b1 || memWrite !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre_req got %b%b want 11", memReq, memWrite);
        end
        if (memWData !== 32'h12345678) begin miscompares++; $display("FAIL rst_pre_wdata got %h want 12345678", memWData); end
        #1;
        reset = 1'b1; write = 1'b0;
        #1;
        vectors += 3;
        if (memReq !== 1'b0)   begin miscompares++; $display("FAIL rst_async_memReq got %b want 0", memReq); end
        if (stall !== 1'b0)    begin miscompares++; $display("FAIL rst_async_stall got %b want 0", stall); end
        if (memWData !== 32'h0) begin miscompares++; $display("FAIL rst_async_wdata got %h want 0", memWData); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        ack_delay = 0; rd_word = 32'h55AA00FF;
        do_access(1'b1, 1'b0, 2'b11, 32'h08, 32'h0, st, cy, rq, ms, ra, to);
        vectors += 4;
        if (wr_count != w0)         begin miscompares++; $display("FAIL rst_no_write got %0d want %0d", wr_count, w0); end
        if (rData !== 32'h55AA00FF) begin miscompares++; $display("FAIL rst_next_rData got %h want 55aa00ff", rData); end
        if (ra !== 16'h2)           begin miscompares++; $display("FAIL rst_next_memAddr got %h want 0002", ra); end
        if (cy != 3)                begin miscompares++; $display("FAIL rst_next_latency got %0d want 3", cy); end
    endtask

    task automatic test_zero_wait;
        int st, cy, r0; logic rq, ms, to; logic [15:0] ra;
        ack_delay = 0; rd_word = 32'hFFFFFFFF;
        do_access(1'b0, 1'b1, 2'b01, 32'h00, 32'h0000BEEF, st, cy, rq, ms, ra, to);
        vectors += 3;
        if (wr_data !== 32'hFFFFBEEF) begin miscompares++; $display("FAIL zw_hstore_wdata got %h want ffffbeef", wr_data); end
        if (cy != 4)                  begin miscompares++; $display("FAIL zw_hstore_latency got %0d want 4", cy); end
        if (st != 3)                  begin miscompares++; $display("FAIL zw_hstore_stalls got %0d want 3", st); end
        r0 = rd_count;
        do_access(1'b1, 1'b1, 2'b11, 32'h30, 32'h0BADF00D, st, cy, rq, ms, ra, to);
        vectors += 4;
        if (wr_data !== 32'h0BADF00D) begin miscompares++; $display("FAIL both_wdata got %h want 0badf00d", wr_data); end
        if (wr_addr !== 16'hC)        begin miscompares++; $display("FAIL both_waddr got %h want 000c", wr_addr); end
        if (rd_count != r0)           begin miscompares++; $display("FAIL both_no_read got %0d want %0d", rd_count, r0); end
        if (cy != 3)                  begin miscompares++; $display("FAIL both_latency got %0d want 3", cy); end
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_byte_store;
        test_subword_load;
        test_misalign;
        test_reset_mid_write;
        test_zero_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
